// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle WIDTH-bit adder/subtractor. Operands are captured on an
//   in_valid/in_ready handshake. The block then adds CHUNK bits per cycle,
//   passing the carry between chunks in a register. The result is held
//   behind an out_valid/out_ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid to capture operands
//   RUN   | adding chunk cnt_q, carry_q feeds the next chunk
//   DONE  | out_valid=1, sum/cout/ovf stable until out_ready
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    operand handshake (a, b, cin, sub)
//   a, b                  WIDTH-bit operands
//   cin                   carry-in (add) / active-low borrow-in (subtract)
//   sub                   1: a + ~b + cin
//   out_valid, out_ready  result handshake
//   sum, cout, ovf        result, carry out of MSB, signed overflow
module serial_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CW-1:0]    cnt_q;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             msb_cin;
    logic             last_chunk;

    assign a_chunk    = a_q[cnt_q*CHUNK +: CHUNK];
    assign b_chunk    = b_q[cnt_q*CHUNK +: CHUNK];
    assign chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk's top bit, recovered from its sum bit; on the
    // last chunk this is the carry into the operand MSB.
    assign msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
    assign last_chunk = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        // Subtraction is a + ~b + cin, so b is inverted once here.
                        b_q     <= b ^ {WIDTH{sub}};
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[cnt_q*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
                    carry_q <= chunk_res[CHUNK];
                    if (last_chunk) begin
                        cout_q <= chunk_res[CHUNK];
                        ovf_q  <= msb_cin ^ chunk_res[CHUNK];
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // WIDTH=8, CHUNK=2 instance
    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       cin8 = 1'b0, sub8 = 1'b0, co8, of8;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .ovf(of8)
    );

    // WIDTH=32 sweep: CHUNK = 1, 4, 32, shared inputs
    logic        iv32 = 1'b0, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic        cin32 = 1'b0, sub32 = 1'b0;
    logic        ir32 [3];
    logic        ov32 [3];
    logic [31:0] s32  [3];
    logic        co32 [3];
    logic        of32 [3];

    serial_chunk_adder #(.WIDTH(32), .CHUNK(1)) dut32_c1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32[0]),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32[0]), .out_ready(or32),
        .sum(s32[0]), .cout(co32[0]), .ovf(of32[0])
    );
    serial_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut32_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32[1]),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32[1]), .out_ready(or32),
        .sum(s32[1]), .cout(co32[1]), .ovf(of32[1])
    );
    serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut32_c32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32[2]),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32[2]), .out_ready(or32),
        .sum(s32[2]), .cout(co32[2]), .ovf(of32[2])
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain arithmetic on w-bit values. Returns {cout, ovf, sum[31:0]}.
    // Overflow from the sign rule: same-signed addends giving a differently signed result.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                            input logic tc, input logic ts);
        longint unsigned m, aa, bb, tot, s;
        logic co, ov, sa, sb, ss;
        m   = (64'd1 << w) - 64'd1;
        aa  = 64'(ta) & m;
        bb  = ts ? (~64'(tb)) & m : 64'(tb) & m;
        tot = aa + bb + 64'(tc);
        s   = tot & m;
        co  = tot[w];
        sa  = aa[w-1];
        sb  = bb[w-1];
        ss  = s[w-1];
        ov  = (sa == sb) && (ss != sa);
        return {co, ov, s[31:0]};
    endfunction

    function automatic logic [63:0] res8();
        return {30'b0, co8, of8, 24'b0, s8};
    endfunction

    // One full transaction on the 8-bit instance, checking latency and result.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts, input logic [33:0] exp);
        int cyc;
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        check_eq({tag, "_busy"}, 64'(ir8), 64'd0);
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"}, 64'(cyc), 64'd4);
        check_eq({tag, "_res"}, res8(), 64'(exp));
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check_eq({tag, "_ovdrop"}, 64'(ov8), 64'd0);
        check_eq({tag, "_rdy"}, 64'(ir8), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] exp;
        logic [7:0]  ra, rb;
        logic        rc, rs;
        logic [2:0]  done;
        logic [63:0] snap;
        int          cyc;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_idle_rdy", 64'(ir8), 64'd1);

        // Leave a result in DONE, then reset mid-clock with no edge following.
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("pre_rst_valid", 64'(ov8), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rdy", 64'(ir8), 64'd1);
        check_eq("async_rst_ov", 64'(ov8), 64'd0);
        check_eq("async_rst_res", res8(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run8("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 32'h80});
        run8("add_carry", 8'hFF, 8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 32'h01});
        run8("sub_neg",   8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFE});
        run8("sub_ovf",   8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7F});

        // Backpressure with inputs churning during RUN and DONE.
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'($urandom);
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        check_eq("bp_lat", 64'(cyc), 64'd4);
        snap = res8();
        check_eq("bp_res", snap, {30'b0, 1'b0, 1'b0, 24'b0, 8'h77});
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
            cin8 = 1'($urandom); sub8 = 1'($urandom);
            @(negedge clk);
            check_eq("bp_hold_res", res8(), {30'b0, 1'b0, 1'b0, 24'b0, 8'h77});
            check_eq("bp_hold_ov", 64'(ov8), 64'd1);
            check_eq("bp_hold_rdy", 64'(ir8), 64'd0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check_eq("bp_rel_ov", 64'(ov8), 64'd0);
        check_eq("bp_rel_rdy", 64'(ir8), 64'd1);
        @(negedge clk);
        check_eq("bp_no_reaccept", 64'(ir8), 64'd1);

        // Reset after chunk 2 of RUN.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrun_rst_ov", 64'(ov8), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrun_rst_rdy", 64'(ir8), 64'd1);
        check_eq("midrun_rst_ov2", 64'(ov8), 64'd0);
        run8("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, {1'b0, 1'b0, 32'h30});

        // Random vectors on the 8-bit instance.
        for (int v = 0; v < 200; v++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            run8("rnd8", ra, rb, rc, rs, ref_add(8, {24'b0, ra}, {24'b0, rb}, rc, rs));
        end

        // Random sweep across the three 32-bit configurations.
        for (int v = 0; v < 1000; v++) begin
            cyc = 0;
            while (!(ir32[0] && ir32[1] && ir32[2]) && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            a32 = $urandom; b32 = $urandom;
            cin32 = 1'($urandom); sub32 = 1'($urandom);
            exp = ref_add(32, a32, b32, cin32, sub32);
            iv32 = 1'b1;
            @(negedge clk);
            iv32 = 1'b0;
            done = 3'b000;
            cyc = 0;
            while (done != 3'b111 && cyc < 40) begin
                for (int k = 0; k < 3; k++) begin
                    if (ov32[k] && !done[k]) begin
                        check_eq($sformatf("sweep_k%0d", k),
                                 {30'b0, co32[k], of32[k], s32[k]}, 64'(exp));
                        done[k] = 1'b1;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            if (done != 3'b111) check_eq("sweep_timeout", 64'(done), 64'd7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
